// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state and aluop
// encodings, opcode/funct codes and the per-state control word.
package mc_pkg;

  typedef logic       u1;
  typedef logic [1:0] u2;
  typedef logic [2:0] u3;
  typedef logic [5:0] u6;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPEEX  = 4'd6,
    RTYPEWB  = 4'd7,
    BRANCHEX = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JEX      = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_RSVD  = 2'b11
  } aluop_t;

  localparam u6 OP_RTYPE = 6'b000000;
  localparam u6 OP_LW    = 6'b100011;
  localparam u6 OP_SW    = 6'b101011;
  localparam u6 OP_BEQ   = 6'b000100;
  localparam u6 OP_BNE   = 6'b000101;
  localparam u6 OP_ADDI  = 6'b001000;
  localparam u6 OP_J     = 6'b000010;

  localparam u6 FN_ADD = 6'b100000;
  localparam u6 FN_SUB = 6'b100010;
  localparam u6 FN_AND = 6'b100100;
  localparam u6 FN_OR  = 6'b100101;
  localparam u6 FN_SLT = 6'b101010;

  localparam u3 ALU_ADD = 3'b010;
  localparam u3 ALU_SUB = 3'b110;
  localparam u3 ALU_AND = 3'b000;
  localparam u3 ALU_OR  = 3'b001;
  localparam u3 ALU_SLT = 3'b111;

  typedef struct packed {
    u1      pcwrite;
    u1      fetch_rdy;
    u1      branch;
    u1      branch_ne;
    u1      iord;
    u1      memwrite;
    u1      regwrite;
    u1      regdst;
    u1      memtoreg;
    u1      alusrca;
    u2      alusrcb;
    u2      pcsrc;
    aluop_t aluop;
  } ctrl_t;

  // Moore control word for a state; op only picks beq vs bne in BRANCHEX.
  function automatic ctrl_t ctrl_of(input state_t s, input u6 op);
    ctrl_t c;
    c       = '0;
    c.aluop = ALUOP_ADD;
    case (s)
      FETCH:    begin c.fetch_rdy = 1'b1; c.alusrcb = 2'b01; end
      DECODE:   c.alusrcb = 2'b11;
      MEMADR:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      MEMRD:    c.iord = 1'b1;
      MEMWB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:    begin c.iord = 1'b1; c.memwrite = 1'b1; end
      RTYPEEX:  begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
      RTYPEWB:  begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BRANCHEX: begin
        c.alusrca   = 1'b1;
        c.aluop     = ALUOP_SUB;
        c.pcsrc     = 2'b01;
        c.branch    = (op == OP_BEQ);
        c.branch_ne = (op == OP_BNE);
      end
      ADDIEX:   begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      ADDIWB:   c.regwrite = 1'b1;
      JEX:      begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default:  c.aluop = ALUOP_ADD;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_controller_alu_decoder.sv
// Combinational ALU control decode from aluop and the R-type funct field.
module alu_decoder
  import mc_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // aluop selects a fixed operation or defers to funct for R-type
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: Moore FSM with registered control word,
// memory-ready stalls in FETCH/MEMRD/MEMWR and combinational pcen.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_t r_state;
  ctrl_t  r_ctrl;
  state_t w_next;
  ctrl_t  w_ctrl;
  logic   w_op_legal;
  logic   w_mem_go;

  // Next-state selection, including decode of op and memory stalls
  always_comb begin
    w_next     = FETCH;
    w_op_legal = 1'b1;
    case (r_state)
      FETCH:    if (mem_ready) w_next = DECODE; else w_next = FETCH;
      DECODE: begin
        case (op)
          OP_RTYPE:      w_next = RTYPEEX;
          OP_LW, OP_SW:  w_next = MEMADR;
          OP_BEQ, OP_BNE: w_next = BRANCHEX;
          OP_ADDI:       w_next = ADDIEX;
          OP_J:          w_next = JEX;
          default: begin
            w_next     = FETCH;
            w_op_legal = 1'b0;
          end
        endcase
      end
      MEMADR:   if (op == OP_LW) w_next = MEMRD; else w_next = MEMWR;
      MEMRD:    if (mem_ready) w_next = MEMWB; else w_next = MEMRD;
      MEMWB:    w_next = FETCH;
      MEMWR:    if (mem_ready) w_next = FETCH; else w_next = MEMWR;
      RTYPEEX:  w_next = RTYPEWB;
      RTYPEWB:  w_next = FETCH;
      BRANCHEX: w_next = FETCH;
      ADDIEX:   w_next = ADDIWB;
      ADDIWB:   w_next = FETCH;
      JEX:      w_next = FETCH;
      default:  w_next = FETCH;
    endcase
  end

  // State register with the control word registered alongside it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FETCH;
      r_ctrl  <= ctrl_of(FETCH, op);
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_of(w_next, op);
    end
  end

  // Reset presents the FETCH word immediately, before the edge lands
  always_comb begin
    if (reset) begin
      w_ctrl = ctrl_of(FETCH, op);
    end else begin
      w_ctrl = r_ctrl;
    end
  end

  assign w_mem_go   = w_ctrl.fetch_rdy & mem_ready;
  assign pcen       = ~reset & (w_ctrl.pcwrite | w_mem_go |
                                (w_ctrl.branch & zero) |
                                (w_ctrl.branch_ne & ~zero));
  assign irwrite    = ~reset & w_mem_go;
  assign memwrite   = ~reset & w_ctrl.memwrite;
  assign regwrite   = ~reset & w_ctrl.regwrite;
  assign iord       = w_ctrl.iord;
  assign regdst     = w_ctrl.regdst;
  assign memtoreg   = w_ctrl.memtoreg;
  assign alusrca    = w_ctrl.alusrca;
  assign alusrcb    = w_ctrl.alusrcb;
  assign pcsrc      = w_ctrl.pcsrc;
  assign illegal_op = ~reset & (r_state == DECODE) & ~w_op_legal;
  assign state      = r_state;

  alu_decoder u_alu_decoder (
    .aluop      (w_ctrl.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Cycle-by-cycle scoreboard bench for mc_controller.
module tb_mc_controller;
  import mc_pkg::*;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [5:0] FN0 = 6'b000000;

  logic       clk = 1'b0;
  logic       reset, zero, mem_ready;
  logic [5:0] op, funct;
  logic       pcen, iord, memwrite, irwrite, regwrite, regdst, memtoreg, alusrca, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  typedef struct packed {
    logic [3:0] st;
    logic       pcen, irw, memw, regw, ill;
    logic [2:0] aluc;
    logic       iord, regdst, memtoreg, alusrca;
    logic [1:0] srcb, pcsrc;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc_n = 0;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memwrite(memwrite),
    .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op),
    .state(state)
  );

  task automatic check_val(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc_n, got, exp);
    end
  endtask

  // Mux-select values each state must present (iord, regdst, memtoreg, alusrca, srcb, pcsrc)
  function automatic exp_t sel_of(input state_t s);
    exp_t e;
    e = '0;
    case (s)
      FETCH:    e.srcb = 2'b01;
      DECODE:   e.srcb = 2'b11;
      MEMADR:   begin e.alusrca = 1'b1; e.srcb = 2'b10; end
      MEMRD:    e.iord = 1'b1;
      MEMWB:    e.memtoreg = 1'b1;
      MEMWR:    e.iord = 1'b1;
      RTYPEEX:  e.alusrca = 1'b1;
      RTYPEWB:  e.regdst = 1'b1;
      BRANCHEX: begin e.alusrca = 1'b1; e.pcsrc = 2'b01; end
      ADDIEX:   begin e.alusrca = 1'b1; e.srcb = 2'b10; end
      JEX:      e.pcsrc = 2'b10;
      default:  e.srcb = 2'b00;
    endcase
    return e;
  endfunction

  task automatic drive(input logic rst, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic mr, input state_t st,
                       input logic pc, input logic irw, input logic memw,
                       input logic regw, input logic ill, input logic [2:0] aluc);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; op = o; funct = f; zero = z; mem_ready = mr;
    e      = sel_of(rst ? FETCH : st);
    e.st   = st;
    e.pcen = pc;  e.irw = irw;   e.memw = memw;
    e.regw = regw; e.ill = ill;  e.aluc = aluc;
    sb_q.push_back(e);
  endtask

  // Pop the expectation for this cycle and compare mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      cyc_n++;
      check_val("state",    state,                 e.st);
      check_val("pcen",     {3'b000, pcen},        {3'b000, e.pcen});
      check_val("irwrite",  {3'b000, irwrite},     {3'b000, e.irw});
      check_val("memwrite", {3'b000, memwrite},    {3'b000, e.memw});
      check_val("regwrite", {3'b000, regwrite},    {3'b000, e.regw});
      check_val("illegal",  {3'b000, illegal_op},  {3'b000, e.ill});
      check_val("aluctl",   {1'b0, alucontrol},    {1'b0, e.aluc});
      check_val("iord",     {3'b000, iord},        {3'b000, e.iord});
      check_val("regdst",   {3'b000, regdst},      {3'b000, e.regdst});
      check_val("memtoreg", {3'b000, memtoreg},    {3'b000, e.memtoreg});
      check_val("alusrca",  {3'b000, alusrca},     {3'b000, e.alusrca});
      check_val("alusrcb",  {2'b00, alusrcb},      {2'b00, e.srcb});
      check_val("pcsrc",    {2'b00, pcsrc},        {2'b00, e.pcsrc});
    end
  end

  task automatic rtype(input logic [5:0] f, input logic [2:0] aluc);
    drive(L, OP_RTYPE, f, L, H, FETCH,   H, H, L, L, L, ALU_ADD);
    drive(L, OP_RTYPE, f, L, H, DECODE,  L, L, L, L, L, ALU_ADD);
    drive(L, OP_RTYPE, f, L, H, RTYPEEX, L, L, L, L, L, aluc);
    drive(L, OP_RTYPE, f, L, H, RTYPEWB, L, L, L, H, L, ALU_ADD);
  endtask

  task automatic branch(input logic [5:0] o, input logic z, input logic taken);
    drive(L, o, FN0, z, H, FETCH,    H, H, L, L, L, ALU_ADD);
    drive(L, o, FN0, z, H, DECODE,   L, L, L, L, L, ALU_ADD);
    drive(L, o, FN0, z, H, BRANCHEX, taken, L, L, L, L, ALU_SUB);
  endtask

  initial begin
    int left;
    reset = 1'b1; op = 6'b000000; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    drive(H, OP_RTYPE, FN0, L, L, FETCH, L, L, L, L, L, ALU_ADD);

    // addi then sw, memory always ready
    drive(L, OP_ADDI, FN0, L, H, FETCH,  H, H, L, L, L, ALU_ADD);
    drive(L, OP_ADDI, FN0, L, H, DECODE, L, L, L, L, L, ALU_ADD);
    drive(L, OP_ADDI, FN0, L, H, ADDIEX, L, L, L, L, L, ALU_ADD);
    drive(L, OP_ADDI, FN0, L, H, ADDIWB, L, L, L, H, L, ALU_ADD);
    drive(L, OP_SW,   FN0, L, H, FETCH,  H, H, L, L, L, ALU_ADD);
    drive(L, OP_SW,   FN0, L, H, DECODE, L, L, L, L, L, ALU_ADD);
    drive(L, OP_SW,   FN0, L, H, MEMADR, L, L, L, L, L, ALU_ADD);
    drive(L, OP_SW,   FN0, L, H, MEMWR,  L, L, H, L, L, ALU_ADD);

    // lw with a fetch stall and three MEMRD wait cycles
    drive(L, OP_LW, FN0, L, L, FETCH,  L, L, L, L, L, ALU_ADD);
    drive(L, OP_LW, FN0, L, H, FETCH,  H, H, L, L, L, ALU_ADD);
    drive(L, OP_LW, FN0, L, H, DECODE, L, L, L, L, L, ALU_ADD);
    drive(L, OP_LW, FN0, L, H, MEMADR, L, L, L, L, L, ALU_ADD);
    for (int i = 0; i < 3; i++)
      drive(L, OP_LW, FN0, L, L, MEMRD, L, L, L, L, L, ALU_ADD);
    drive(L, OP_LW, FN0, L, H, MEMRD,  L, L, L, L, L, ALU_ADD);
    drive(L, OP_LW, FN0, L, H, MEMWB,  L, L, L, H, L, ALU_ADD);

    branch(OP_BEQ, H, H);
    branch(OP_BEQ, L, L);
    branch(OP_BNE, L, H);
    branch(OP_BNE, H, L);

    rtype(FN_SLT, ALU_SLT);
    rtype(FN_SUB, ALU_SUB);
    rtype(FN_AND, ALU_AND);
    rtype(6'b111111, ALU_ADD);

    // jump
    drive(L, OP_J, FN0, L, H, FETCH,  H, H, L, L, L, ALU_ADD);
    drive(L, OP_J, FN0, L, H, DECODE, L, L, L, L, L, ALU_ADD);
    drive(L, OP_J, FN0, L, H, JEX,    H, L, L, L, L, ALU_ADD);

    // unsupported opcode
    drive(L, 6'b111111, FN0, L, H, FETCH,  H, H, L, L, L, ALU_ADD);
    drive(L, 6'b111111, FN0, L, H, DECODE, L, L, L, L, H, ALU_ADD);
    drive(L, 6'b111111, FN0, L, L, FETCH,  L, L, L, L, L, ALU_ADD);

    // reset asserted while a store waits on memory
    drive(L, OP_SW, FN0, L, H, FETCH,  H, H, L, L, L, ALU_ADD);
    drive(L, OP_SW, FN0, L, H, DECODE, L, L, L, L, L, ALU_ADD);
    drive(L, OP_SW, FN0, L, H, MEMADR, L, L, L, L, L, ALU_ADD);
    drive(L, OP_SW, FN0, L, L, MEMWR,  L, L, H, L, L, ALU_ADD);
    drive(H, OP_SW, FN0, L, L, MEMWR,  L, L, L, L, L, ALU_ADD);
    drive(H, OP_SW, FN0, L, H, FETCH,  L, L, L, L, L, ALU_ADD);
    drive(L, OP_SW, FN0, L, H, FETCH,  H, H, L, L, L, ALU_ADD);
    drive(L, OP_SW, FN0, L, H, DECODE, L, L, L, L, L, ALU_ADD);

    @(negedge clk);
    @(negedge clk);
    left = sb_q.size();
    check_val("sb_left", left[3:0], 4'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Main control unit for the multicycle MIPS datapath.
- A Moore FSM that sequences fetch, decode, execute, memory and writeback.
- Decodes opcode/funct into datapath mux selects, ALU control and write enables.
- Adds a memory-ready handshake so FETCH, MEMRD and MEMWR stall on slow memory.

Parameters:
- None. Opcodes, funct codes and state encodings live in the shared package.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; forces state to FETCH
- op  input  6  instr[31:26] from instruction register
- funct  input  6  instr[5:0]
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory access completes this cycle
- pcen  output  1  PC register enable
- iord  output  1  memory address select: 0=PC, 1=ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register enable
- regwrite  output  1  register file write enable
- regdst  output  1  write reg select: 0=rt, 1=rd
- memtoreg  output  1  writeback select: 0=ALUOut, 1=Data
- alusrca  output  1  ALU A select: 0=PC, 1=A reg
- alusrcb  output  2  00=B, 01=const 4, 10=SignImm, 11=SignImm<<2
- pcsrc  output  2  00=ALUResult, 01=ALUOut, 10=jump target
- alucontrol  output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal_op  output  1  one-cycle pulse on unsupported opcode
- state  output  4  current state, for debug and bench

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BRANCHEX, ADDIEX, ADDIWB, JEX.
- Reset:
  - reset high at a clock edge sets state to FETCH.
  - While reset is high, pcen, irwrite, regwrite and memwrite are forced to 0.
  - All other outputs show their FETCH values.
  - Reset mid-instruction abandons it; no partial writes occur after the edge.
- FETCH:
  - iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00.
  - irwrite and pcwrite are asserted only when mem_ready=1.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alusrca=0, alusrcb=11, aluop=00.
  - Next state by op:
    - 000000 (R-type) -> RTYPEEX
    - 100011 (lw) and 101011 (sw) -> MEMADR
    - 000100 (beq) and 000101 (bne) -> BRANCHEX
    - 001000 (addi) -> ADDIEX
    - 000010 (j) -> JEX
    - any other op -> FETCH, with illegal_op=1 for this cycle only
- MEMADR: alusrca=1, alusrcb=10, aluop=00. Goes to MEMRD if op=lw, otherwise MEMWR.
- MEMRD: iord=1. Holds until mem_ready=1, then goes to MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1. Goes to FETCH.
- MEMWR:
  - iord=1, memwrite=1, held level for the whole wait.
  - Goes to FETCH when mem_ready=1.
- RTYPEEX: alusrca=1, alusrcb=00, aluop=10. Goes to RTYPEWB.
- RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Goes to FETCH.
- BRANCHEX:
  - alusrca=1, alusrcb=00, aluop=01, pcsrc=01.
  - branch=1 for beq; branch_ne=1 for bne.
  - Goes to FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00. Goes to ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1. Goes to FETCH.
- JEX: pcsrc=10, pcwrite=1. Goes to FETCH.
- Unlisted outputs default to 0 in every state.
- pcen = pcwrite | (branch & zero) | (branch_ne & ~zero). This is the only Mealy term besides the mem_ready gating.
- ALU decode (combinational):
  - aluop 00 -> 010; aluop 01 -> 110.
  - aluop 10 decodes funct: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111, any other funct->010.
  - aluop 11 is unused and also maps to 010.
- Unreachable state encodings recover to FETCH on the next edge.

Decomposition:
- Package mc_pkg holds:
  - the state enum (4-bit) and opcode/funct localparams;
  - the aluop enum;
  - the u1/u2/u3/u6 typedefs consistent with common.svh.
- Sub-module alu_decoder (inputs aluop, funct; output alucontrol) is purely combinational and instanced once.

Test Plan:
- addi then sw with mem_ready=1: op=001000, then op=101011.
  - Required state trace: FETCH, DECODE, ADDIEX, ADDIWB, FETCH, DECODE, MEMADR, MEMWR.
  - memwrite=1 only in cycle 8; regwrite=1 only in cycle 4.
- lw with mem_ready low for 3 cycles in MEMRD:
  - state holds MEMRD for 4 cycles with iord=1 and regwrite=0;
  - then MEMWB with memtoreg=1 and regwrite=1.
- beq with zero=1 gives pcen=1 and pcsrc=01 in BRANCHEX; zero=0 gives pcen=0. bne behaves the inverse.
- R-type funct=101010 in RTYPEEX gives alucontrol=111; funct=100010 gives 110; RTYPEWB gives regdst=1.
- op=111111 in DECODE gives illegal_op=1 for exactly 1 cycle, then FETCH; no write enable asserts.
- reset=1 during MEMWR with mem_ready=0:
  - memwrite=0 immediately;
  - state=FETCH after the edge;
  - pcen=0 until reset deasserts.
